// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback slice:
// opcodes, register index width and the EX issue record.
package alu_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 3;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_LESS = 3'd2;
    localparam logic [2:0] OP_EQ   = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;

    typedef struct packed {
        logic [2:0]       op;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
    } issue_t;

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: two async read ports, one write
// port, async clear; r0 is hardwired to zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREG = 8,
    parameter int RW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [RW-1:0] raddr1,
    output logic [N-1:0]  rdata1,
    input  logic [RW-1:0] raddr2,
    output logic [N-1:0]  rdata2
);

    logic [N-1:0] rf_q [NREG];
    logic [N-1:0] rf_d [NREG];

    always_comb begin
        rf_d = rf_q;
        if (we && (waddr != '0)) begin
            rf_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_q <= '{default: '0};
        end else begin
            rf_q <= rf_d;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : rf_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : rf_q[raddr2];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand issue into the external ALU (EX register) and result
// capture/writeback (WB register) with EX/WB forwarding.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREG = 8,
    parameter int RW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [RW-1:0] in_rd,
    input  logic [RW-1:0] in_rs1,
    input  logic [RW-1:0] in_rs2,
    input  logic          in_imm_en,
    input  logic [N-1:0]  in_imm,
    output logic [2:0]    alu_opcode,
    output logic [N-1:0]  alu_op_a,
    output logic [N-1:0]  alu_op_b,
    input  logic [N-1:0]  alu_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_rd,
    output logic [N-1:0]  out_data
);

    issue_t        ex_q, ex_d;
    logic          ex_valid_q, ex_valid_d;
    logic          wb_valid_q, wb_valid_d;
    logic [RW-1:0] wb_rd_q, wb_rd_d;
    logic [N-1:0]  wb_data_q, wb_data_d;

    logic          wb_adv;
    logic          ex_adv;
    logic          accept;
    logic          rf_we;
    logic [N-1:0]  rf_a;
    logic [N-1:0]  rf_b;
    logic [N-1:0]  opnd_a;
    logic [N-1:0]  opnd_b;

    alu_regfile #(
        .N    (N),
        .NREG (NREG),
        .RW   (RW)
    ) u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (rf_we),
        .waddr  (wb_rd_q),
        .wdata  (wb_data_q),
        .raddr1 (in_rs1),
        .rdata1 (rf_a),
        .raddr2 (in_rs2),
        .rdata2 (rf_b)
    );

    assign wb_adv   = !wb_valid_q || out_ready;
    assign ex_adv   = ex_valid_q && wb_adv;
    assign in_ready = !ex_valid_q || wb_adv;
    assign accept   = in_valid && in_ready;
    assign rf_we    = wb_valid_q && out_ready;

    // Youngest in-flight producer wins; r0 never forwards.
    function automatic logic [N-1:0] resolve(
        input logic [RW-1:0] rs,
        input logic [N-1:0]  rf_val
    );
        logic [N-1:0] v;
        if (rs == '0) begin
            v = '0;
        end else if (ex_valid_q && (ex_q.rd == rs)) begin
            v = alu_out;
        end else if (wb_valid_q && (wb_rd_q == rs)) begin
            v = wb_data_q;
        end else begin
            v = rf_val;
        end
        return v;
    endfunction

    always_comb begin
        opnd_a = resolve(in_rs1, rf_a);
        opnd_b = in_imm_en ? in_imm : resolve(in_rs2, rf_b);
    end

    always_comb begin
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        if (accept) begin
            ex_d.op    = in_op;
            ex_d.rd    = in_rd;
            ex_d.a     = opnd_a;
            ex_d.b     = opnd_b;
            ex_valid_d = 1'b1;
        end else if (ex_adv) begin
            ex_valid_d = 1'b0;
        end
    end

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        if (ex_adv) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_q.rd;
            wb_data_d  = alu_out;
        end else if (wb_adv) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            ex_q       <= ex_d;
            ex_valid_q <= ex_valid_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign alu_opcode = ex_q.op;
    assign alu_op_a   = ex_q.a;
    assign alu_op_b   = ex_q.b;
    assign out_valid  = wb_valid_q;
    assign out_rd     = wb_rd_q;
    assign out_data   = wb_data_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU
// closing the loop from alu_opcode/op_a/op_b back to alu_out.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [2:0]  in_rd;
    logic [2:0]  in_rs1;
    logic [2:0]  in_rs2;
    logic        in_imm_en;
    logic [31:0] in_imm;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_op_a;
    logic [31:0] alu_op_b;
    logic [31:0] alu_out;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_rd;
    logic [31:0] out_data;

    int checks;
    int failures;

    logic [2:0]  q_rd[$];
    logic [31:0] q_data[$];

    alu_issue_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm_en  (in_imm_en),
        .in_imm     (in_imm),
        .alu_opcode (alu_opcode),
        .alu_op_a   (alu_op_a),
        .alu_op_b   (alu_op_b),
        .alu_out    (alu_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_data   (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_out = 32'd0;
        case (alu_opcode)
            3'd0: alu_out = alu_op_a + alu_op_b;
            3'd1: alu_out = alu_op_a - alu_op_b;
            3'd2: alu_out = {31'd0, alu_op_a < alu_op_b};
            3'd3: alu_out = {31'd0, alu_op_a == alu_op_b};
            3'd4: alu_out = alu_op_a | alu_op_b;
            3'd5: alu_out = alu_op_a & alu_op_b;
            3'd6: alu_out = ~alu_op_a;
            default: alu_out = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q_rd.push_back(out_rd);
            q_data.push_back(out_data);
        end
    end

    task automatic issue(
        input logic [2:0]  op,
        input logic [2:0]  rd,
        input logic [2:0]  rs1,
        input logic [2:0]  rs2,
        input logic        ie,
        input logic [31:0] imm
    );
        bit done;
        done      = 1'b0;
        in_op     = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm_en = ie;
        in_imm    = imm;
        in_valid  = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            if (in_ready) done = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL issue_timeout in_ready=%b required=1", in_ready);
        end
    endtask

    task automatic pop(output logic [2:0] rd, output logic [31:0] d);
        int k;
        k = 0;
        while (q_rd.size() == 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (q_rd.size() == 0) begin
            rd = 'x;
            d  = 'x;
        end else begin
            rd = q_rd.pop_front();
            d  = q_data.pop_front();
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_imm_en = 1'b0;
        in_imm    = '0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, out_rd, out_data} !== 36'd0) begin
            failures++;
            $display("FAIL reset_out got v=%b rd=%0d d=%h required 0",
                     out_valid, out_rd, out_data);
        end
        checks++;
        if ({alu_opcode, alu_op_a, alu_op_b} !== 67'd0) begin
            failures++;
            $display("FAIL reset_alu got op=%0d a=%h b=%h required 0",
                     alu_opcode, alu_op_a, alu_op_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got %b required 1", in_ready);
        end
    endtask

    task automatic test_addi();
        logic [2:0]  rd;
        logic [31:0] d;
        issue(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5);
        in_valid = 1'b0;
        checks++;
        if (alu_op_a !== 32'd0 || alu_op_b !== 32'd5 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL addi_ex got a=%h b=%h ov=%b required 0/5/0",
                     alu_op_a, alu_op_b, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd5 || out_rd !== 3'd1) begin
            failures++;
            $display("FAIL addi_wb got v=%b d=%h rd=%0d required 1/5/1",
                     out_valid, out_data, out_rd);
        end
        pop(rd, d);
        checks++;
        if (rd !== 3'd1 || d !== 32'd5) begin
            failures++;
            $display("FAIL addi_out got rd=%0d d=%h required 1/5", rd, d);
        end
        issue(3'd4, 3'd7, 3'd1, 3'd0, 1'b0, 32'd0);
        in_valid = 1'b0;
        pop(rd, d);
        checks++;
        if (rd !== 3'd7 || d !== 32'd5) begin
            failures++;
            $display("FAIL addi_rf1 got rd=%0d d=%h required 7/5", rd, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  rd;
        logic [31:0] d;
        issue(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5);
        issue(3'd0, 3'd2, 3'd1, 3'd1, 1'b0, 32'd0);
        checks++;
        if (alu_op_a !== 32'd5 || alu_op_b !== 32'd5) begin
            failures++;
            $display("FAIL b2b_ex_fwd got a=%h b=%h required 5/5",
                     alu_op_a, alu_op_b);
        end
        issue(3'd1, 3'd3, 3'd2, 3'd1, 1'b0, 32'd0);
        in_valid = 1'b0;
        checks++;
        if (alu_opcode !== 3'd1 || alu_op_a !== 32'd10 || alu_op_b !== 32'd5) begin
            failures++;
            $display("FAIL b2b_sub_ops got op=%0d a=%h b=%h required 1/a/5",
                     alu_opcode, alu_op_a, alu_op_b);
        end
        pop(rd, d);
        checks++;
        if (rd !== 3'd1 || d !== 32'd5) begin
            failures++;
            $display("FAIL b2b_out1 got rd=%0d d=%h required 1/5", rd, d);
        end
        pop(rd, d);
        checks++;
        if (rd !== 3'd2 || d !== 32'd10) begin
            failures++;
            $display("FAIL b2b_out2 got rd=%0d d=%h required 2/a", rd, d);
        end
        pop(rd, d);
        checks++;
        if (rd !== 3'd3 || d !== 32'd5) begin
            failures++;
            $display("FAIL b2b_out3 got rd=%0d d=%h required 3/5", rd, d);
        end
    endtask

    task automatic test_backpressure();
        logic [2:0]  rd;
        logic [31:0] d;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd0;
        in_rs1    = 3'd0;
        in_rs2    = 3'd0;
        in_imm_en = 1'b1;
        in_rd     = 3'd4;
        in_imm    = 32'd11;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready1 got %b required 1", in_ready);
        end
        in_rd  = 3'd5;
        in_imm = 32'd22;
        @(posedge clk);
        @(negedge clk);
        in_rd  = 3'd6;
        in_imm = 32'd33;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_stall_ready c=%0d got %b required 0",
                         c, in_ready);
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'd11 || out_rd !== 3'd4) begin
                failures++;
                $display("FAIL bp_hold c=%0d got v=%b d=%h rd=%0d required 1/b/4",
                         c, out_valid, out_data, out_rd);
            end
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        pop(rd, d);
        checks++;
        if (rd !== 3'd4 || d !== 32'd11) begin
            failures++;
            $display("FAIL bp_out1 got rd=%0d d=%h required 4/b", rd, d);
        end
        pop(rd, d);
        checks++;
        if (rd !== 3'd5 || d !== 32'd22) begin
            failures++;
            $display("FAIL bp_out2 got rd=%0d d=%h required 5/16", rd, d);
        end
        pop(rd, d);
        checks++;
        if (rd !== 3'd6 || d !== 32'd33) begin
            failures++;
            $display("FAIL bp_out3 got rd=%0d d=%h required 6/21", rd, d);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (q_rd.size() != 0) begin
            failures++;
            $display("FAIL bp_dup got %0d extra results required 0",
                     q_rd.size());
        end
    endtask

    task automatic test_r0();
        logic [2:0]  rd;
        logic [31:0] d;
        issue(3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 32'd7);
        issue(3'd4, 3'd4, 3'd0, 3'd0, 1'b0, 32'd0);
        in_valid = 1'b0;
        pop(rd, d);
        checks++;
        if (rd !== 3'd0 || d !== 32'd7) begin
            failures++;
            $display("FAIL r0_write got rd=%0d d=%h required 0/7", rd, d);
        end
        pop(rd, d);
        checks++;
        if (rd !== 3'd4 || d !== 32'd0) begin
            failures++;
            $display("FAIL r0_read got rd=%0d d=%h required 4/0", rd, d);
        end
    endtask

    task automatic test_alu_ops();
        logic [2:0]  rd;
        logic [31:0] d;
        logic [2:0]  exp_rd [6];
        logic [31:0] exp_d  [6];
        exp_rd = '{3'd1, 3'd2, 3'd5, 3'd6, 3'd6, 3'd7};
        exp_d  = '{32'd3, 32'hFFFF_FFFF, 32'd1, 32'd1,
                   32'hFFFF_FFFF, 32'd0};
        issue(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 32'd3);
        issue(3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFF);
        issue(3'd2, 3'd5, 3'd1, 3'd2, 1'b0, 32'd0);
        issue(3'd3, 3'd6, 3'd1, 3'd0, 1'b1, 32'd3);
        issue(3'd6, 3'd6, 3'd0, 3'd3, 1'b0, 32'd0);
        issue(3'd7, 3'd7, 3'd1, 3'd2, 1'b0, 32'd0);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pop(rd, d);
            checks++;
            if (rd !== exp_rd[i] || d !== exp_d[i]) begin
                failures++;
                $display("FAIL ops_%0d got rd=%0d d=%h required %0d/%h",
                         i, rd, d, exp_rd[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0]  rd;
        logic [31:0] d;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd0;
        in_rs1    = 3'd0;
        in_imm_en = 1'b1;
        in_rd     = 3'd3;
        in_imm    = 32'd9;
        @(posedge clk);
        @(negedge clk);
        in_rd  = 3'd4;
        in_imm = 32'd8;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rmid_full got v=%b rdy=%b required 1/0",
                     out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd0) begin
            failures++;
            $display("FAIL rmid_async got v=%b d=%h required 0/0",
                     out_valid, out_data);
        end
        @(negedge clk);
        q_rd.delete();
        q_data.delete();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rmid_ready got %b required 1", in_ready);
        end
        for (int i = 1; i < 8; i++) begin
            issue(3'd4, 3'(i), 3'(i), 3'd0, 1'b0, 32'd0);
        end
        in_valid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            pop(rd, d);
            checks++;
            if (rd !== 3'(i) || d !== 32'd0) begin
                failures++;
                $display("FAIL rmid_rf%0d got rd=%0d d=%h required %0d/0",
                         i, rd, d, i);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_r0();
        test_alu_ops();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
